// File: rtl/biquad_section_tdm.sv
// ----------------------------------------------------------------------------
// biquad_section_tdm
//   Time-multiplexed direct-form-II second-order IIR section. One shared
//   signed multiplier is stepped through the five products of the section,
//   one product per FSM state. It serves CHANNELS independent channels, each
//   with its own (w1, w2) delay pair. The coefficients are shared by all
//   channels and can be written at runtime.
//
//     w = x + a1*w1 + a2*w2        (feedback terms are added)
//     y = b0*w + b1*w1 + b2*w2
//
//   Optional build macro:
//     BIQUAD_SAT_EN  - narrowing from the accumulator saturates, and any clip
//                      sets the sticky 'sat' flag. When the macro is not
//                      defined, narrowing wraps and 'sat' is tied low.
//
// Parameters
//   DATA_W    sample/coefficient width, signed two's complement
//   FRAC_W    fraction bits of the Q format used by samples and coefficients
//   CHANNELS  number of independent channels
//   CH_W      channel tag width (derived)
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_data/in_ch        input sample and its channel tag
//   in_valid/in_ready    input handshake; in_ready is high only while idle
//   out_data/out_ch      output sample and its channel tag
//   out_valid/out_ready  output handshake; held stable until accepted
//   coef_wr/coef_addr    coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2)
//   coef_data            coefficient value, same Q format as the data
//   ch_err               one-cycle pulse when a sample with a bad tag is dropped
//   sat                  sticky saturation flag
// ----------------------------------------------------------------------------
module biquad_section_tdm #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int CHANNELS = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              coef_wr,
    input  logic [2:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              ch_err,
    output logic              sat
);

    // Three guard bits are enough for the sum of the input term and two products.
    localparam int ACC_W = 2*DATA_W + 3;
    localparam int PRD_W = 2*DATA_W;
    localparam logic [CH_W:0] CH_LIM = CHANNELS[CH_W:0];

    typedef enum logic [2:0] {IDLE, FB1, FB2, FF0, FF1, FF2, OUT} state_t;

    state_t                    state_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic [CH_W-1:0]           ch_reg;
    logic signed [DATA_W-1:0]  w_reg;
    logic signed [DATA_W-1:0]  b0_reg, b1_reg, b2_reg, a1_reg, a2_reg;
    logic [DATA_W-1:0]         out_data_reg;
    logic [CH_W-1:0]           out_ch_reg;
    logic                      out_valid_reg;
    logic                      in_ready_reg;
    logic                      ch_err_reg;

    logic signed [DATA_W-1:0]  w1_rd [CHANNELS];
    logic signed [DATA_W-1:0]  w2_rd [CHANNELS];
    logic signed [DATA_W-1:0]  w1_sel, w2_sel;
    logic signed [DATA_W-1:0]  mul_a, mul_b;
    logic signed [PRD_W-1:0]   prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   x_ext;
    logic [DATA_W-1:0]         narrow_val;
    logic                      accept;
    logic                      ch_bad;
    logic                      commit;

    assign accept = (state_reg == IDLE) && in_valid && in_ready_reg;
    assign ch_bad = ({1'b0, in_ch} >= CH_LIM);
    // Channel state advances only when the output is actually taken.
    assign commit = (state_reg == OUT) && out_ready;

    // Per-channel delay pairs.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic signed [DATA_W-1:0] w1_reg;
        logic signed [DATA_W-1:0] w2_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                w1_reg <= '0;
                w2_reg <= '0;
            end else if (commit && (ch_reg == CH_W'(gi))) begin
                w2_reg <= w1_reg;
                w1_reg <= w_reg;
            end
        end

        assign w1_rd[gi] = w1_reg;
        assign w2_rd[gi] = w2_reg;
    end

    assign w1_sel = w1_rd[ch_reg];
    assign w2_sel = w2_rd[ch_reg];

    // Shared multiplier: operands are steered by the current state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_reg)
            FB1:     begin mul_a = a1_reg; mul_b = w1_sel; end
            FB2:     begin mul_a = a2_reg; mul_b = w2_sel; end
            FF0:     begin mul_a = b0_reg; mul_b = w_reg;  end
            FF1:     begin mul_a = b1_reg; mul_b = w1_sel; end
            FF2:     begin mul_a = b2_reg; mul_b = w2_sel; end
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
    assign acc_sum  = acc_reg + prod_ext;
    assign x_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

`ifdef BIQUAD_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] shifted;
    logic                    clip;
    logic                    sat_reg;

    // Arithmetic shift floors; out-of-range results clip to the rails.
    always_comb begin
        shifted    = acc_sum >>> FRAC_W;
        clip       = 1'b0;
        narrow_val = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            narrow_val = {1'b0, {(DATA_W-1){1'b1}}};
            clip       = 1'b1;
        end else if (shifted < SAT_MIN) begin
            narrow_val = {1'b1, {(DATA_W-1){1'b0}}};
            clip       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_reg <= 1'b0;
        end else if (clip && ((state_reg == FB2) || (state_reg == FF2))) begin
            sat_reg <= 1'b1;
        end
    end

    assign sat = sat_reg;
`else
    // Wrap: keep the low DATA_W bits of the floored quotient.
    assign narrow_val = acc_sum[FRAC_W +: DATA_W];
    assign sat        = 1'b0;
`endif

    // Sequencer: one multiply-accumulate per state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ch_reg        <= '0;
            w_reg         <= '0;
            b0_reg        <= DATA_W'(1) << FRAC_W;
            b1_reg        <= '0;
            b2_reg        <= '0;
            a1_reg        <= '0;
            a2_reg        <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            ch_err_reg    <= 1'b0;
        end else begin
            ch_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        // A sample accept takes priority over a coefficient write.
                        if (ch_bad) begin
                            ch_err_reg <= 1'b1;
                        end else begin
                            acc_reg      <= x_ext <<< FRAC_W;
                            ch_reg       <= in_ch;
                            in_ready_reg <= 1'b0;
                            state_reg    <= FB1;
                        end
                    end else if (coef_wr) begin
                        case (coef_addr)
                            3'd0:    b0_reg <= coef_data;
                            3'd1:    b1_reg <= coef_data;
                            3'd2:    b2_reg <= coef_data;
                            3'd3:    a1_reg <= coef_data;
                            3'd4:    a2_reg <= coef_data;
                            default: ;
                        endcase
                    end
                end
                FB1: begin
                    acc_reg   <= acc_sum;
                    state_reg <= FB2;
                end
                FB2: begin
                    acc_reg   <= acc_sum;
                    w_reg     <= narrow_val;
                    state_reg <= FF0;
                end
                FF0: begin
                    // Feed-forward sum restarts from the b0 product.
                    acc_reg   <= prod_ext;
                    state_reg <= FF1;
                end
                FF1: begin
                    acc_reg   <= acc_sum;
                    state_reg <= FF2;
                end
                FF2: begin
                    out_data_reg  <= narrow_val;
                    out_ch_reg    <= ch_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign ch_err    = ch_err_reg;

endmodule
